// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN          : default datapath / PC width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0), used for pipeline bubbles
//   fetch_state_e : fetch FSM states (issue request, wait for response, hold buffered word)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears to bubble, pc 0)
//   bubble_i   : force a bubble (NOP, valid=0); highest priority after reset
//   load_i     : capture {pc_i, instr_i} as a valid instruction
//   hold_i     : keep current contents when not loading
//   pc_i       : PC of incoming instruction
//   instr_i    : incoming instruction word
//   pc_o       : held PC
//   instr_o    : held instruction
//   valid_o    : held entry is a real instruction
// With neither load_i nor hold_i asserted the register advances with no
// instruction available, so it takes a bubble. A bubble leaves pc_o as is.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble_i,
  input  logic            load_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (bubble_i || (!load_i && !hold_i)) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM, one-entry response buffer and IF/ID.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pc_write        : hazard unit PC enable (0 = stall)
//   if_id_write     : hazard unit IF/ID enable (0 = hold)
//   flush           : taken branch/jump, redirect to branch_target
//   branch_target   : redirect address (low two bits ignored)
//   imem_req        : one-cycle request strobe per fetch
//   imem_addr       : fetch address (current PC)
//   imem_rvalid     : response valid
//   imem_rdata      : response instruction word
//   if_id_pc/instr/valid : IF/ID contents
//   if_id_rs1/rs2   : source register fields of the IF/ID instruction
//   fetch_busy      : a request is outstanding
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [4:0]      if_id_rs1,
  output logic [4:0]      if_id_rs2,
  output logic            fetch_busy
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     buf_q, buf_d;

  logic            advance;
  logic            deliver_mem;
  logic            deliver_buf;
  logic            ifid_load;
  logic            ifid_hold;
  logic [31:0]     ifid_instr_in;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_plus4;

  assign advance     = pc_write & if_id_write;
  assign redirect_pc = branch_target & ~XLEN'(3);
  assign pc_plus4    = pc_q + XLEN'(4);

  // A response is only usable if it is not the stale answer to a request
  // issued before a redirect.
  assign deliver_mem   = (state_q == FETCH_WAIT) && imem_rvalid && !drop_q && !flush && advance;
  assign deliver_buf   = (state_q == FETCH_HOLD) && !flush && advance;
  assign ifid_load     = deliver_mem | deliver_buf;
  assign ifid_hold     = ~advance;
  assign ifid_instr_in = deliver_buf ? buf_q : imem_rdata;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    buf_d   = buf_q;
    unique case (state_q)
      FETCH_ISSUE: begin
        state_d = FETCH_WAIT;
        // The request just issued will still answer; mark it for discard.
        if (flush) drop_d = 1'b1;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (flush || drop_q) begin
            state_d = FETCH_ISSUE;
          end else if (advance) begin
            state_d = FETCH_ISSUE;
            pc_d    = pc_plus4;
          end else begin
            state_d = FETCH_HOLD;
            buf_d   = imem_rdata;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (flush) begin
          state_d = FETCH_ISSUE;
          buf_d   = '0;
        end else if (advance) begin
          state_d = FETCH_ISSUE;
          pc_d    = pc_plus4;
        end
      end
      default: state_d = FETCH_ISSUE;
    endcase
    if (flush) pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_ISSUE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
    end
  end

  // Request is suppressed while reset is held so the first strobe lands in
  // the first cycle after release.
  assign imem_req   = (state_q == FETCH_ISSUE) && !rst;
  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == FETCH_WAIT);

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .bubble_i(flush),
    .load_i  (ifid_load),
    .hold_i  (ifid_hold),
    .pc_i    (pc_q),
    .instr_i (ifid_instr_in),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign if_id_rs1 = if_id_instr[19:15];
  assign if_id_rs2 = if_id_instr[24:20];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        if_id_write = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        fetch_busy;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .flush(flush), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .fetch_busy(fetch_busy)
  );

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;

  // Memory responder: latency 1..3 cycles after each request (mem_lat=0 -> random).
  int lat_cnt = 0;
  int mem_lat = 1;

  // Transaction-level reference: a request is outstanding or not, its answer
  // may be marked as stale, and at most one returned word may be waiting.
  logic [31:0] m_pc;
  bit          m_out, m_disc;
  logic [31:0] m_held[$];
  logic [31:0] m_ipc, m_iinstr;
  bit          m_ivalid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_bubble();
    m_iinstr = NOP_INSTR;
    m_ivalid = 0;
  endtask

  task automatic m_load(input logic [31:0] pc, input logic [31:0] w);
    m_ipc = pc;
    m_iinstr = w;
    m_ivalid = 1;
  endtask

  task automatic cycle(input bit r, input bit pw, input bit iw, input bit fl, input logic [31:0] tgt);
    bit exp_req, adv, resp;
    logic [31:0] w;
    @(negedge clk);
    rst = r; pc_write = pw; if_id_write = iw; flush = fl; branch_target = tgt;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (r) lat_cnt = 0;
    else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) imem_rvalid = 1'b1;
    end
    #1;
    if (!r && imem_req === 1'b1) lat_cnt = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;

    exp_req = !r && !m_out && (m_held.size() == 0);
    if (chk_en) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, m_out});
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ivalid});
      chk("if_id_instr", if_id_instr, m_iinstr);
      if (m_ivalid) chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_rs1", {27'b0, if_id_rs1}, {27'b0, m_iinstr[19:15]});
      chk("if_id_rs2", {27'b0, if_id_rs2}, {27'b0, m_iinstr[24:20]});
    end

    // Reference update for the coming clock edge.
    if (r) begin
      m_pc = RPC; m_out = 0; m_disc = 0; m_held.delete();
      m_ipc = '0; m_iinstr = NOP_INSTR; m_ivalid = 0;
    end else begin
      adv  = pw && iw;
      resp = m_out && imem_rvalid;
      if (fl) begin
        m_pc = tgt & 32'hFFFF_FFFC;
        m_bubble();
        m_held.delete();
        if (exp_req) begin m_out = 1; m_disc = 1; end
        else if (resp) begin m_out = 0; m_disc = 0; end
        else if (m_out) m_disc = 1;
      end else if (exp_req) begin
        m_out = 1;
        if (adv) m_bubble();
      end else if (resp) begin
        m_out = 0;
        if (m_disc) begin
          m_disc = 0;
          if (adv) m_bubble();
        end else if (adv) begin
          m_load(m_pc, imem_rdata);
          m_pc = m_pc + 32'd4;
        end else m_held.push_back(imem_rdata);
      end else if (m_held.size() > 0 && adv) begin
        w = m_held.pop_front();
        m_load(m_pc, w);
        m_pc = m_pc + 32'd4;
      end else if (adv) m_bubble();
    end
  endtask

  task automatic cyc(input bit pw, input bit iw, input bit fl, input logic [31:0] tgt);
    cycle(1'b0, pw, iw, fl, tgt);
  endtask

  initial begin
    bit r, pw, iw, fl;
    logic [31:0] tgt;
    m_pc = RPC; m_out = 0; m_disc = 0; m_ipc = '0; m_iinstr = NOP_INSTR; m_ivalid = 0;

    // Reset.
    cycle(1, 0, 0, 0, 0);
    chk_en = 1;
    cycle(1, 0, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'd0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    chk("rst_pc", if_id_pc, 32'h0);

    // Straight-line fetch, 1-cycle memory.
    cyc(1, 1, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(1, 1, 0, 0);
    chk("wait_busy", {31'b0, fetch_busy}, 32'd1);
    cyc(1, 1, 0, 0);
    chk("addr4", imem_addr, 32'h4);
    chk("ifid_pc0", if_id_pc, 32'h0);
    chk("ifid_v0", {31'b0, if_id_valid}, 32'd1);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("addr8", imem_addr, 32'h8);
    chk("ifid_pc4", if_id_pc, 32'h4);

    // Stall three cycles while word for PC=8 returns.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0);
      chk("hold_noreq", {31'b0, imem_req}, 32'd0);
      chk("hold_ifid", if_id_pc, 32'h4);
    end
    cyc(1, 1, 0, 0);
    mem_lat = 3;
    cyc(1, 1, 0, 0);
    chk("after_hold_addr", imem_addr, 32'hC);
    chk("after_hold_pc", if_id_pc, 32'h8);

    // Flush during WAIT: outstanding word dropped.
    cyc(1, 1, 1, 32'h100);
    cyc(1, 1, 0, 0);
    chk("flush_bubble_v", {31'b0, if_id_valid}, 32'd0);
    chk("flush_bubble_i", if_id_instr, 32'h0000_0013);
    cyc(1, 1, 0, 0);
    mem_lat = 1;
    cyc(1, 1, 0, 0);
    chk("redirect_addr", imem_addr, 32'h100);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("addr104", imem_addr, 32'h104);
    chk("ifid_pc100", if_id_pc, 32'h100);

    // Flush coincident with rvalid while IF/ID write is held.
    cyc(1, 0, 1, 32'h200);
    cyc(1, 1, 0, 0);
    chk("flush_rv_addr", imem_addr, 32'h200);
    chk("flush_rv_valid", {31'b0, if_id_valid}, 32'd0);

    // Misaligned target and PC wrap.
    cyc(1, 1, 1, 32'h103);
    cyc(1, 1, 0, 0);
    chk("align_addr", imem_addr, 32'h100);
    cyc(1, 1, 1, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_ifid_pc", if_id_pc, 32'hFFFF_FFFC);

    // Reset while waiting.
    cycle(1, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    chk("rstw_busy", {31'b0, fetch_busy}, 32'd0);
    chk("rstw_req", {31'b0, imem_req}, 32'd0);
    chk("rstw_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rstw_rs1", {27'b0, if_id_rs1}, 32'd0);
    cyc(1, 1, 0, 0);
    chk("rstw_addr", imem_addr, RPC);
    chk("rstw_req1", {31'b0, imem_req}, 32'd1);

    // Randomized traffic against the reference.
    mem_lat = 0;
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      pw = ($urandom_range(0, 7) != 0);
      iw = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 9) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(r, pw, iw, fl, tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: XLEN, 32, datapath and PC width.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pc_write  in  1  PC advance enable from hazard unit (0 = stall).
REQ-006 if_id_write  in  1  IF/ID load enable from hazard unit (0 = hold).
REQ-007 flush  in  1  taken branch/jump from EX; redirect to branch_target.
REQ-008 branch_target  in  XLEN  redirect address.
REQ-009 imem_req  out  1  instruction memory request strobe, one cycle per fetch.
REQ-010 imem_addr  out  XLEN  fetch address, equal to PC.
REQ-011 imem_rvalid  in  1  response valid, at least 1 cycle after imem_req.
REQ-012 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-013 if_id_pc  out  XLEN  PC of instruction held in IF/ID.
REQ-014 if_id_instr  out  32  instruction held in IF/ID.
REQ-015 if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 if_id_rs1  out  5  if_id_instr[19:15], combinational from IF/ID register.
REQ-017 if_id_rs2  out  5  if_id_instr[24:20], combinational from IF/ID register.
REQ-018 fetch_busy  out  1  high in WAIT state.

Function
REQ-019 advance = pc_write AND if_id_write; hazard stall = advance low.
REQ-020 FSM states: ISSUE, WAIT, HOLD.
REQ-021 ISSUE: imem_req=1, imem_addr=PC; next state WAIT unconditionally.
REQ-022 WAIT: imem_req=0; on imem_rvalid with no pending drop and advance=1 -> load IF/ID {PC, imem_rdata, valid=1}, PC<=PC+4, go ISSUE.
REQ-023 WAIT: on imem_rvalid with no pending drop and advance=0 -> store word in one-entry buffer, go HOLD; PC unchanged.
REQ-024 HOLD: imem_req=0; when advance=1 -> load IF/ID from buffer with valid=1, PC<=PC+4, go ISSUE.
REQ-025 When advance=1 and no instruction is delivered that cycle (ISSUE, or WAIT without rvalid), IF/ID loads bubble: instr=NOP 32'h0000_0013, valid=0.
REQ-026 When if_id_write=0 and no flush, IF/ID contents hold unchanged.
REQ-027 flush has priority over stall: IF/ID <= bubble regardless of if_id_write; PC <= {branch_target[XLEN-1:2], 2'b00}.
REQ-028 flush in ISSUE: the issued request is outstanding; set drop flag, go WAIT.
REQ-029 flush in WAIT: set drop flag, stay WAIT; the next imem_rvalid is discarded, drop flag cleared, go ISSUE at redirected PC.
REQ-030 flush in HOLD: buffer discarded, go ISSUE at redirected PC.
REQ-031 flush coincident with imem_rvalid in WAIT: returned word discarded, go ISSUE at redirected PC; no drop flag set.
REQ-032 PC arithmetic modulo 2^XLEN; PC+4 wraps from 32'hFFFF_FFFC to 0.
REQ-033 At most one memory request outstanding at any time.

Reset
REQ-034 On rst: PC=RESET_PC, state=ISSUE, drop flag=0, buffer cleared.
REQ-035 On rst: if_id_pc=0, if_id_instr=NOP, if_id_valid=0, if_id_rs1=0, if_id_rs2=0, imem_req=0, fetch_busy=0.
REQ-036 First imem_req=1 with imem_addr=RESET_PC occurs in the first cycle rst is low.
REQ-037 rst mid-transaction overrides all; a response arriving after reset is ignored unless the FSM is in WAIT.

Structure
REQ-038 Shared package riscv_pkg holds XLEN, NOP_INSTR constant, and fetch FSM state typedef.
REQ-039 One sub-module: if_id_reg (IF/ID register with load, bubble, hold inputs); PC, FSM and buffer live in fetch_unit.

Verification
REQ-040 Reset release, rvalid 1 cycle after each req, advance=1 -> addrs 0,4,8; if_id_pc 0,4 with valid=1 on successive loads.
REQ-041 Stall: advance=0 for 3 cycles when word at PC=8 returns -> HOLD, no new req, IF/ID unchanged; advance=1 -> if_id_pc=8, next req addr=12.
REQ-042 flush with branch_target=32'h100 during WAIT -> pending word dropped, IF/ID bubble, next req addr=32'h100.
REQ-043 flush coincident with rvalid and if_id_write=0 -> IF/ID still becomes bubble, next req addr=branch_target.
REQ-044 branch_target=32'h103 -> req addr 32'h100; PC=32'hFFFF_FFFC advance -> next addr 0.
REQ-045 rst asserted in WAIT -> outputs to reset values next cycle; after release req addr=RESET_PC.
